// File: rtl/vdp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdp_pkg
// Description : Shared types and sizing helpers for the dot-product feeder
//               and its MAC partner.
// Revision    : 1.0 - initial release
// ============================================================================
package vdp_pkg;

    // Feeder sequencing states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FEED    = 3'd1,
        DRAIN   = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4
    } vdp_feed_state_t;

    // Accumulator width: a full 2N-bit product plus K-1 guard bits, so the
    // sum of K worst-case products can never overflow.
    function automatic int vdp_out_w(input int n, input int k);
        return 2 * n + k - 1;
    endfunction

    // Pair counter width; a K=1 build still needs a 1-bit counter.
    function automatic int vdp_cnt_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_nnbit_kcc.sv
`default_nettype none
// ============================================================================
// Module      : mac_nnbit_kcc
// Description : Signed multiply-accumulate. Every rising edge either loads
//               g*e (rst=1) or adds g*e to the running sum (rst=0). There is
//               no enable: the driver feeds zeros when it has nothing to add.
// Ports       : clk      - rising-edge clock
//               rst      - clear; 1 loads the product instead of accumulating
//               g_input  - signed operand (N bits)
//               e_input  - signed operand (N bits)
//               o        - signed accumulator (2N+K-1 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module mac_nnbit_kcc
    import vdp_pkg::*;
#(
    parameter int N   = 8,
    parameter int K   = 4,
    parameter int O_W = vdp_out_w(N, K)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [N-1:0]   g_input,
    input  logic signed [N-1:0]   e_input,
    output logic signed [O_W-1:0] o
);

    logic signed [2*N-1:0] w_prod;
    logic signed [O_W-1:0] w_prod_ext;

    assign w_prod     = g_input * e_input;
    assign w_prod_ext = O_W'(w_prod);   // signed cast sign-extends

    always_ff @(posedge clk) begin
        if (rst) begin
            o <= w_prod_ext;
        end else begin
            o <= o + w_prod_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vdp_feeder_kcc.sv
`default_nettype none
// ============================================================================
// Module      : vdp_feeder_kcc
// Description : Takes K signed operand pairs from a valid/ready stream, feeds
//               them one per cycle into a MAC (clearing it with the first
//               pair), waits for the last product to land, then offers the
//               accumulated dot product on a valid/ready output stream.
// Ports       : clk, rst (async, active low)
//               in_valid/in_ready, g_in, e_in    - operand pair stream
//               mac_rst, mac_g, mac_e, mac_o     - MAC initiator interface
//               out_valid/out_ready, result      - dot product stream
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_feeder_kcc
    import vdp_pkg::*;
#(
    parameter int N   = 8,
    parameter int K   = 4,
    parameter int O_W = vdp_out_w(N, K)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [N-1:0]   g_in,
    input  logic signed [N-1:0]   e_in,
    output logic                  mac_rst,
    output logic signed [N-1:0]   mac_g,
    output logic signed [N-1:0]   mac_e,
    input  logic signed [O_W-1:0] mac_o,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [O_W-1:0] result
);

    localparam int                c_cnt_w    = vdp_cnt_w(K);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(K - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    vdp_feed_state_t             r_state,     w_state_nxt;
    logic [c_cnt_w-1:0]          r_cnt,       w_cnt_nxt;
    logic                        r_in_ready,  w_in_ready_nxt;
    logic                        r_mac_rst,   w_mac_rst_nxt;
    logic signed [N-1:0]         r_mac_g,     w_mac_g_nxt;
    logic signed [N-1:0]         r_mac_e,     w_mac_e_nxt;
    logic                        r_out_valid, w_out_valid_nxt;
    logic signed [O_W-1:0]       r_result,    w_result_nxt;
    logic                        w_accept;

    // in_ready is only ever high in FEED, so this is the FEED accept
    assign w_accept = in_valid && r_in_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_in_ready_nxt  = r_in_ready;
        w_mac_rst_nxt   = 1'b0;
        w_mac_g_nxt     = '0;          // zero product unless a pair is taken
        w_mac_e_nxt     = '0;
        w_out_valid_nxt = r_out_valid;
        w_result_nxt    = r_result;

        case (r_state)
            IDLE: begin
                w_state_nxt    = FEED;
                w_in_ready_nxt = 1'b1;
            end
            FEED: begin
                if (w_accept) begin
                    w_mac_g_nxt   = g_in;
                    w_mac_e_nxt   = e_in;
                    w_mac_rst_nxt = (r_cnt == '0);
                    if (r_cnt == c_cnt_last) begin
                        w_cnt_nxt      = '0;
                        w_state_nxt    = DRAIN;
                        w_in_ready_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
            end
            DRAIN: begin
                // MAC absorbs the last pair on this edge
                w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                w_result_nxt    = mac_o;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                    w_state_nxt     = FEED;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_in_ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_mac_rst   <= 1'b0;
            r_mac_g     <= '0;
            r_mac_e     <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_mac_rst   <= w_mac_rst_nxt;
            r_mac_g     <= w_mac_g_nxt;
            r_mac_e     <= w_mac_e_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_result    <= w_result_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign mac_rst   = r_mac_rst;
    assign mac_g     = r_mac_g;
    assign mac_e     = r_mac_e;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_vdp_feeder_kcc.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdp_feeder_kcc
// Description : Self-checking bench for vdp_feeder_kcc. A K=4 feeder and a
//               K=1 feeder each drive their own mac_nnbit_kcc. Expected dot
//               products come from a plain sum-of-products reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdp_feeder_kcc;

    localparam int N    = 8;
    localparam int KA   = 4;
    localparam int KB   = 1;
    localparam int OWA  = 2 * N + KA - 1;
    localparam int OWB  = 2 * N + KB - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // K=4 instance signals
    logic                  a_in_valid = 1'b0, a_in_ready, a_mac_rst;
    logic signed [N-1:0]   a_g = '0, a_e = '0, a_mac_g, a_mac_e;
    logic signed [OWA-1:0] a_mac_o, a_result;
    logic                  a_out_valid, a_out_ready = 1'b0;

    // K=1 instance signals
    logic                  b_in_valid = 1'b0, b_in_ready, b_mac_rst;
    logic signed [N-1:0]   b_g = '0, b_e = '0, b_mac_g, b_mac_e;
    logic signed [OWB-1:0] b_mac_o, b_result;
    logic                  b_out_valid, b_out_ready = 1'b0;

    vdp_feeder_kcc #(.N(N), .K(KA), .O_W(OWA)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .g_in(a_g), .e_in(a_e),
        .mac_rst(a_mac_rst), .mac_g(a_mac_g), .mac_e(a_mac_e), .mac_o(a_mac_o),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .result(a_result)
    );

    mac_nnbit_kcc #(.N(N), .K(KA), .O_W(OWA)) u_mac_a (
        .clk(clk), .rst(a_mac_rst), .g_input(a_mac_g), .e_input(a_mac_e), .o(a_mac_o)
    );

    vdp_feeder_kcc #(.N(N), .K(KB), .O_W(OWB)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .g_in(b_g), .e_in(b_e),
        .mac_rst(b_mac_rst), .mac_g(b_mac_g), .mac_e(b_mac_e), .mac_o(b_mac_o),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result)
    );

    mac_nnbit_kcc #(.N(N), .K(KB), .O_W(OWB)) u_mac_b (
        .clk(clk), .rst(b_mac_rst), .g_input(b_mac_g), .e_input(b_mac_e), .o(b_mac_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0][7:0] g;
        logic [3:0][7:0] e;
        logic [3:0][3:0] gap;   // idle in_valid cycles before pair i
        int              hold;  // out_ready-low cycles after out_valid rises
        int              exp;
    } vec_t;

    function automatic logic [3:0][7:0] p4(input int v0, input int v1, input int v2, input int v3);
        logic [3:0][7:0] r;
        r[0] = 8'(v0); r[1] = 8'(v1); r[2] = 8'(v2); r[3] = 8'(v3);
        return r;
    endfunction

    // Reference: plain signed sum of products
    function automatic int ref_dot(input logic [3:0][7:0] g, input logic [3:0][7:0] e);
        int s = 0;
        for (int i = 0; i < 4; i++) s += int'($signed(g[i])) * int'($signed(e[i]));
        return s;
    endfunction

    // Streams one vector into the K=4 instance and consumes its result.
    task automatic run_a(input vec_t v, output int waited);
        waited = 0;
        a_out_ready = (v.hold == 0);
        while (!a_in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("a_in_ready_wait", int'(a_in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b0;
            for (int j = 0; j < int'(v.gap[i]); j++) begin
                @(negedge clk);
                chk("a_gap_in_ready", int'(a_in_ready), 1);
                chk("a_gap_mac_g", int'(a_mac_g), 0);
                chk("a_gap_mac_rst", int'(a_mac_rst), 0);
            end
            a_in_valid = 1'b1;
            a_g = $signed(v.g[i]);
            a_e = $signed(v.e[i]);
            @(negedge clk);
            chk("a_mac_rst", int'(a_mac_rst), (i == 0) ? 1 : 0);
            chk("a_mac_g", int'(a_mac_g), int'($signed(v.g[i])));
            chk("a_mac_e", int'(a_mac_e), int'($signed(v.e[i])));
            chk("a_in_ready_after_accept", int'(a_in_ready), (i < 3) ? 1 : 0);
        end
        a_in_valid = 1'b0;
        a_g = '0;
        a_e = '0;
        @(negedge clk);
        chk("a_out_valid_t1", int'(a_out_valid), 0);
        @(negedge clk);
        chk("a_out_valid_t2", int'(a_out_valid), 1);
        chk("a_result", int'(a_result), v.exp);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("a_hold_out_valid", int'(a_out_valid), 1);
            chk("a_hold_result", int'(a_result), v.exp);
            chk("a_hold_in_ready", int'(a_in_ready), 0);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("a_out_valid_drop", int'(a_out_valid), 0);
        chk("a_in_ready_back", int'(a_in_ready), 1);
    endtask

    // One pair into the K=1 instance.
    task automatic run_b(input int g, input int e, input int exp);
        int waited = 0;
        while (!b_in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("b_in_ready_wait", int'(b_in_ready), 1);
        b_in_valid = 1'b1;
        b_g = 8'(g);
        b_e = 8'(e);
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("b_mac_rst", int'(b_mac_rst), 1);
        chk("b_in_ready_drop", int'(b_in_ready), 0);
        @(negedge clk);
        chk("b_out_valid_t1", int'(b_out_valid), 0);
        @(negedge clk);
        chk("b_out_valid_t2", int'(b_out_valid), 1);
        chk("b_result", int'(b_result), exp);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        chk("b_out_valid_drop", int'(b_out_valid), 0);
    endtask

    vec_t tv[4];

    initial begin
        vec_t v;
        int   waited;

        tv[0] = '{g: p4(23, -23, 5, -1), e: p4(99, 99, -7, -128), gap: 16'h0000, hold: 0, exp: 93};
        tv[1] = '{g: p4(23, -23, 5, -1), e: p4(99, 99, -7, -128), gap: 16'h0300, hold: 0, exp: 93};
        tv[2] = '{g: p4(-128, -128, -128, -128), e: p4(-128, -128, -128, -128), gap: 16'h0000, hold: 5, exp: 65536};
        tv[3] = '{g: p4(127, -128, 0, 1), e: p4(127, 127, 55, -1), gap: 16'h1021, hold: 1, exp: -128};

        // Reset values and release
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(a_in_ready), 0);
        chk("rst_out_valid", int'(a_out_valid), 0);
        chk("rst_mac_rst", int'(a_mac_rst), 0);
        chk("rst_mac_g", int'(a_mac_g), 0);
        chk("rst_result", int'(a_result), 0);
        rst = 1'b1;
        #1 chk("release_in_ready_pre", int'(a_in_ready), 0);
        @(negedge clk);
        chk("release_in_ready_post", int'(a_in_ready), 1);

        // Table vectors; tv[0] and tv[1] stream back-to-back with out_ready high
        for (int k = 0; k < 4; k++) begin
            run_a(tv[k], waited);
            if (k == 1) chk("stream_no_wait", waited, 0);
        end

        // Randomized vectors against the sum-of-products reference
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < 4; i++) begin
                v.g[i]   = 8'($urandom);
                v.e[i]   = 8'($urandom);
                v.gap[i] = 4'($urandom_range(0, 2));
            end
            v.hold = int'($urandom_range(0, 3));
            v.exp  = ref_dot(v.g, v.e);
            run_a(v, waited);
        end

        // Reset mid-vector: two pairs accepted, then an async reset
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_g = 8'sd5; a_e = 8'sd5;
        @(negedge clk);
        a_g = 8'sd6; a_e = 8'sd6;
        @(negedge clk);
        a_in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_in_ready", int'(a_in_ready), 0);
        chk("async_out_valid", int'(a_out_valid), 0);
        chk("async_mac_rst", int'(a_mac_rst), 0);
        chk("async_mac_g", int'(a_mac_g), 0);
        chk("async_mac_e", int'(a_mac_e), 0);
        chk("async_result", int'(a_result), 0);
        @(negedge clk);
        rst = 1'b1;
        v = '{g: p4(1, 2, 3, 4), e: p4(1, 2, 3, 4), gap: 16'h0000, hold: 2, exp: 30};
        run_a(v, waited);

        // K=1 instance: every accept is a complete vector
        run_b(23, -99, -2277);
        run_b(-23, 99, -2277);
        run_b(-23, -99, 2277);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
